mdu_seq: RTL and testbench
==========================

# mdu_seq

Sequencer for the single-cycle CPU's iterative multiply/divide unit. It sits between the control unit, the register-file read ports, the `fun` unit and the HI/LO register. On a mult/multu/div/divu instruction it stalls the PC, latches the operands and issues a start pulse. It then waits for the unit's busy handshake (with a watchdog) and writes the result into HI/LO in the retiring cycle. Divide-by-zero is resolved locally without launching the unit.

## Interface
- `TIMEOUT`, 200: WAIT-cycle limit before forced completion; legal range 2..255.
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `md_req`  in  1  current instruction is mult/multu/div/divu.
- `md_op`  in  2  00 mult, 01 multu, 10 div, 11 divu.
- `rs_val`  in  32  register-file port A data.
- `rt_val`  in  32  register-file port B data.
- `unit_busy`  in  1  iterative unit busy.
- `unit_hi`  in  32  unit HI result.
- `unit_lo`  in  32  unit LO result.
- `pc_ena`  out  1  PC write enable; 0 = stall.
- `unit_start`  out  1  one-cycle start pulse.
- `unit_fun`  out  2  latched `md_op`.
- `unit_a`  out  32  latched `rs_val`.
- `unit_b`  out  32  latched `rt_val`.
- `hilo_we`  out  1  HI/LO write enable.
- `hi_wdata`  out  32  HI write data.
- `lo_wdata`  out  32  LO write data.
- `md_busy`  out  1  sequencer not in IDLE.
- `dz`  out  1  divide-by-zero completion pulse.
- `tmo`  out  1  watchdog completion pulse.

## Operation
- **States:** IDLE, LAUNCH, WAIT, WRITE. Encoding is free.
- **IDLE**
  - `md_req` = 0: stay in IDLE, `pc_ena` = 1.
  - `md_req` = 1: `pc_ena` = 0. Latch `unit_fun` ← `md_op`, `unit_a` ← `rs_val`, `unit_b` ← `rt_val`.
  - If `md_op[1]` = 1 and `rt_val` = 0: load `hi_wdata` ← `rs_val`, `lo_wdata` ← 32'hFFFFFFFF, set dz flag, go to WRITE.
  - Otherwise go to LAUNCH.
- **LAUNCH:** `unit_start` = 1, `pc_ena` = 0. Clear wait counter `cnt` (8 bit). Go to WAIT.
- **WAIT:** `pc_ena` = 0. `cnt` increments each cycle, saturating at 255.
  - If `unit_busy` = 0 and `cnt` ≠ 0: load `hi_wdata` ← `unit_hi`, `lo_wdata` ← `unit_lo`, go to WRITE.
  - Else if `cnt` = `TIMEOUT`-1 and `unit_busy` = 1: load `hi_wdata` = `lo_wdata` = 0, set tmo flag, go to WRITE.
  - `cnt` ≠ 0 masks the first WAIT cycle, covering a unit that raises busy one cycle after start.
- **WRITE:** `hilo_we` = 1, `pc_ena` = 1 (the instruction retires), `dz`/`tmo` reflect their flags. Go to IDLE and clear the flags.
- **Output sources**
  - `md_busy` = (state ≠ IDLE).
  - `pc_ena`, `unit_start`, `hilo_we`, `dz`, `tmo` decode combinationally from state (plus `md_req` in IDLE).
  - All data outputs are registers.
- **Ignored inputs:** `md_req` and operands are ignored outside IDLE. The PC is frozen, so the instruction stays stable until WRITE.
- **Back-to-back requests:** a request sampled in IDLE on the cycle after WRITE starts a new sequence; no bubble is required.

## Timing
- **Reset** (async, immediate): state = IDLE, `cnt` = 0, `unit_fun` = 0, `unit_a` = `unit_b` = `hi_wdata` = `lo_wdata` = 0, flags = 0.
  - Resulting outputs: `unit_start` = `hilo_we` = `md_busy` = `dz` = `tmo` = 0, `pc_ena` = !`md_req`.
  - Reset mid-LAUNCH/WAIT aborts with no HI/LO write; the unit is reset by the same signal.
- **Normal op:** request seen at cycle 0, LAUNCH at 1, first WAIT at 2.
  - If the unit holds busy for N ≥ 1 cycles starting at cycle 2, WRITE occurs at cycle N+3; total stall N+3 cycles.
  - If busy is never raised, WRITE occurs at cycle 4.
- **Divide-by-zero:** request at cycle 0, WRITE at cycle 1; `unit_start` never pulses.
- **Timeout:** WRITE occurs at cycle `TIMEOUT`+2.
- **Write timing:** HI/LO are written on the clock edge ending WRITE, together with the PC update.

## Test plan
- **Reset:** assert `reset` mid-cycle with `md_req` = 0 → all outputs at reset values without waiting for a clock edge; `pc_ena` = 1.
- **mult:** rs = 32'hFFFFFFFF, rt = 2, unit model busy for 3 cycles returning HI = 32'hFFFFFFFF, LO = 32'hFFFFFFFE → `unit_start` pulses at cycle 1 only; `unit_fun` = 00; `hilo_we` at cycle 6 with those values; `pc_ena` low cycles 0–5.
- **divu by zero:** `md_op` = 11, rs = 7, rt = 0 → cycle 1 `hilo_we` = 1, `hi_wdata` = 7, `lo_wdata` = 32'hFFFFFFFF, `dz` = 1; no `unit_start`.
- **Timeout:** `TIMEOUT` = 10, busy stuck high → `tmo` and `hilo_we` at cycle 12, HI = LO = 0, then IDLE.
- **Abort:** pulse `reset` during WAIT (cycle 3) → immediately IDLE, no `hilo_we`; the next request completes normally.
- **Back-to-back:** div (unit N = 2) then multu → second `unit_start` occurs 2 cycles after the first WRITE. Operands latched for the second op are unaffected by `rs_val`/`rt_val` changes during WAIT.

Source files
------------

// File: rtl/mdu_seq.sv
`default_nettype none
// ============================================================================
//  Module   : mdu_seq
//  Purpose  : Sequencer for the iterative multiply/divide unit. Stalls the PC
//             on mult/multu/div/divu, latches the operands, launches the unit,
//             waits on its busy handshake under a watchdog, and writes HI/LO in
//             the retiring cycle. Divide-by-zero completes locally.
//  Revision : 1.0 - initial release
// ============================================================================
module mdu_seq #(
  parameter int TIMEOUT = 200  // WAIT-cycle limit, legal range 2..255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        md_req,
  input  logic [1:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        unit_busy,
  input  logic [31:0] unit_hi,
  input  logic [31:0] unit_lo,
  output logic        pc_ena,
  output logic        unit_start,
  output logic [1:0]  unit_fun,
  output logic [31:0] unit_a,
  output logic [31:0] unit_b,
  output logic        hilo_we,
  output logic [31:0] hi_wdata,
  output logic [31:0] lo_wdata,
  output logic        md_busy,
  output logic        dz,
  output logic        tmo
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_WRITE  = 2'd3
  } state_t;

  // Last WAIT count at which a still-busy unit is abandoned.
  localparam logic [7:0] C_CNT_LAST = 8'(TIMEOUT - 1);
  localparam logic [7:0] C_CNT_MAX  = 8'hFF;

  state_t     r_state;
  logic [7:0] r_cnt;
  logic       r_dz_flag;
  logic       r_tmo_flag;
  logic       w_div_by_zero;

  // Only div/divu (md_op[1] set) can hit the divide-by-zero shortcut.
  assign w_div_by_zero = md_op[1] && (rt_val == 32'd0);

  // Sequencer state, wait counter, completion flags and all data outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= 8'd0;
      r_dz_flag  <= 1'b0;
      r_tmo_flag <= 1'b0;
      unit_fun   <= 2'd0;
      unit_a     <= 32'd0;
      unit_b     <= 32'd0;
      hi_wdata   <= 32'd0;
      lo_wdata   <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (md_req) begin
            unit_fun <= md_op;
            unit_a   <= rs_val;
            unit_b   <= rt_val;
            if (w_div_by_zero) begin
              // Architectural result for x/0: HI keeps the dividend, LO all ones.
              hi_wdata  <= rs_val;
              lo_wdata  <= 32'hFFFF_FFFF;
              r_dz_flag <= 1'b1;
              r_state   <= S_WRITE;
            end else begin
              r_state <= S_LAUNCH;
            end
          end
        end
        S_LAUNCH: begin
          r_cnt   <= 8'd0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (r_cnt != C_CNT_MAX) begin
            r_cnt <= r_cnt + 8'd1;
          end
          // cnt==0 is the first WAIT cycle; a unit may not have raised busy yet.
          if (!unit_busy && (r_cnt != 8'd0)) begin
            hi_wdata <= unit_hi;
            lo_wdata <= unit_lo;
            r_state  <= S_WRITE;
          end else if (unit_busy && (r_cnt == C_CNT_LAST)) begin
            hi_wdata   <= 32'd0;
            lo_wdata   <= 32'd0;
            r_tmo_flag <= 1'b1;
            r_state    <= S_WRITE;
          end
        end
        S_WRITE: begin
          r_dz_flag  <= 1'b0;
          r_tmo_flag <= 1'b0;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Control strobes decode straight from state; PC runs in IDLE (no request) and WRITE.
  always_comb begin
    pc_ena     = 1'b0;
    unit_start = 1'b0;
    hilo_we    = 1'b0;
    dz         = 1'b0;
    tmo        = 1'b0;
    md_busy    = (r_state != S_IDLE);
    case (r_state)
      S_IDLE:   pc_ena = !md_req;
      S_LAUNCH: unit_start = 1'b1;
      S_WAIT:   pc_ena = 1'b0;
      S_WRITE: begin
        pc_ena  = 1'b1;
        hilo_we = 1'b1;
        dz      = r_dz_flag;
        tmo     = r_tmo_flag;
      end
      default: pc_ena = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_mdu_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mdu_seq
//  Purpose  : Self-checking bench for mdu_seq with a reactive multiply/divide
//             unit model and an arithmetic reference for HI/LO and latency.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mdu_seq;

  localparam int TMO   = 10;
  localparam int STUCK = 255;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        md_req = 1'b0;
  logic [1:0]  md_op = 2'd0;
  logic [31:0] rs_val = 32'd0;
  logic [31:0] rt_val = 32'd0;
  logic        unit_busy = 1'b0;
  logic [31:0] unit_hi = 32'd0;
  logic [31:0] unit_lo = 32'd0;
  logic        pc_ena, unit_start, hilo_we, md_busy, dz, tmo;
  logic [1:0]  unit_fun;
  logic [31:0] unit_a, unit_b, hi_wdata, lo_wdata;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  mdu_seq #(.TIMEOUT(TMO)) dut (
    .clock(clock), .reset(reset), .md_req(md_req), .md_op(md_op),
    .rs_val(rs_val), .rt_val(rt_val), .unit_busy(unit_busy),
    .unit_hi(unit_hi), .unit_lo(unit_lo), .pc_ena(pc_ena),
    .unit_start(unit_start), .unit_fun(unit_fun), .unit_a(unit_a),
    .unit_b(unit_b), .hilo_we(hilo_we), .hi_wdata(hi_wdata),
    .lo_wdata(lo_wdata), .md_busy(md_busy), .dz(dz), .tmo(tmo)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [1:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    int          n;       // unit busy cycles after start (0 = never busy)
    int          w;       // expected WRITE cycle, request at cycle 0
    logic [31:0] hi;
    logic [31:0] lo;
    logic        edz;
    logic        etmo;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // MIPS arithmetic: returns {HI, LO}; div puts remainder in HI, quotient in LO.
  function automatic logic [63:0] arith(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      2'd0: return 64'(sa * sb);
      2'd1: return ua * ub;
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (op == 2'd2) begin
          q = sa / sb;
          r = sa % sb;
          return {r[31:0], q[31:0]};
        end
        return {a % b, a / b};
      end
    endcase
  endfunction

  // Reference: completion cycle and results from the sequencing rules.
  function automatic vec_t model(input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt, input int n);
    vec_t v;
    logic [63:0] r;
    v.op = op; v.rs = rs; v.rt = rt; v.n = n;
    v.edz = 1'b0; v.etmo = 1'b0;
    r = arith(op, rs, rt);
    if (op[1] && rt == 32'd0) begin
      v.w = 1; v.edz = 1'b1;
    end else if (n == 0) begin
      v.w = 4;
    end else if (n <= TMO - 1) begin
      v.w = n + 3;
    end else begin
      v.w = TMO + 2; v.etmo = 1'b1; r = 64'd0;
    end
    v.hi = r[63:32];
    v.lo = r[31:0];
    return v;
  endfunction

  // Runs one instruction from request to WRITE; stops after sampling the WRITE cycle.
  task automatic run_op(input vec_t v, input string tag, output int start_cyc, output int write_cyc);
    bit          started = 0;
    int          s = 0;
    logic [63:0] res = 64'd0;
    start_cyc = -1;
    write_cyc = -1;
    for (int c = 0; c <= v.w; c++) begin
      @(posedge clock); #1;
      if (c == 0) begin
        md_req = 1'b1; md_op = v.op; rs_val = v.rs; rt_val = v.rt;
      end else begin
        md_req = 1'($urandom_range(0, 1)); md_op = 2'($urandom_range(0, 3));
        rs_val = $urandom; rt_val = $urandom;
      end
      unit_busy = started && (c > s) && (c <= s + v.n);
      if (started && !unit_busy) {unit_hi, unit_lo} = res;
      else                       {unit_hi, unit_lo} = {$urandom, $urandom};
      @(negedge clock);
      chk({tag, "_ctrl"}, 64'({pc_ena, unit_start, hilo_we, md_busy, dz, tmo}),
          64'({c == v.w, (c == 1) && !v.edz, c == v.w, c != 0, (c == v.w) && v.edz, (c == v.w) && v.etmo}));
      if (unit_start) begin
        started = 1; s = c; start_cyc = cyc;
        res = arith(unit_fun, unit_a, unit_b);
      end
      if (c == 1) begin
        chk({tag, "_fun"}, 64'(unit_fun), 64'(v.op));
        chk({tag, "_a"},   64'(unit_a),   64'(v.rs));
        chk({tag, "_b"},   64'(unit_b),   64'(v.rt));
      end
      if (c == v.w) begin
        chk({tag, "_hi"}, 64'(hi_wdata), 64'(v.hi));
        chk({tag, "_lo"}, 64'(lo_wdata), 64'(v.lo));
        write_cyc = cyc;
      end
    end
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) begin
      @(posedge clock); #1;
      md_req = 1'b0; unit_busy = 1'b0;
      @(negedge clock);
      chk("idle_ctrl", 64'({pc_ena, unit_start, hilo_we, md_busy, dz, tmo}), 64'(6'b100000));
    end
  endtask

  vec_t tbl[$];
  vec_t v;
  int   s1, w1, s2, w2;

  initial begin
    // Directed vectors with hand-computed results (TIMEOUT = 10).
    tbl.push_back('{2'd0, 32'hFFFFFFFF, 32'd2,          3,     6,  32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 1'b0});
    tbl.push_back('{2'd3, 32'd7,        32'd0,          3,     1,  32'd7,        32'hFFFFFFFF, 1'b1, 1'b0});
    tbl.push_back('{2'd0, 32'd3,        32'd4,          STUCK, 12, 32'd0,        32'd0,        1'b0, 1'b1});
    tbl.push_back('{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF,   0,     4,  32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b0});
    tbl.push_back('{2'd2, 32'hFFFFFFF9, 32'd2,          1,     4,  32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b0});
    tbl.push_back('{2'd3, 32'd100,      32'd7,          9,     12, 32'd2,        32'd14,       1'b0, 1'b0});
    tbl.push_back('{2'd2, 32'h80000000, 32'd0,          2,     1,  32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b0});
    tbl.push_back('{2'd1, 32'h00010000, 32'h00010000,   10,    12, 32'd0,        32'd0,        1'b0, 1'b1});
    tbl.push_back('{2'd2, 32'h80000000, 32'hFFFFFFFF,   5,     8,  32'd0,        32'h80000000, 1'b0, 1'b0});

    // Power-on reset: outputs settle without a clock edge.
    #1 reset = 1'b1;
    #1 chk("por_ctrl", 64'({pc_ena, unit_start, hilo_we, md_busy, dz, tmo}), 64'(6'b100000));
    chk("por_data", 64'({unit_fun, unit_a, hi_wdata}), 64'd0);
    @(posedge clock); #3 reset = 1'b0;
    idle(2);

    foreach (tbl[i]) begin
      run_op(tbl[i], $sformatf("vec%0d", i), s1, w1);
      idle(1);
    end

    // Back-to-back: div (N=2) then multu with no idle cycle between.
    run_op('{2'd2, 32'd100, 32'd7, 2, 5, 32'd2, 32'd14, 1'b0, 1'b0}, "b2b0", s1, w1);
    run_op('{2'd1, 32'd3,   32'd5, 1, 4, 32'd0, 32'd15, 1'b0, 1'b0}, "b2b1", s2, w2);
    chk("b2b_gap", 64'(s2 - w1), 64'd2);
    idle(1);

    // Asynchronous reset mid-cycle while idle: registers clear immediately.
    #1 reset = 1'b1;
    #1 chk("rst_ctrl", 64'({pc_ena, unit_start, hilo_we, md_busy, dz, tmo}), 64'(6'b100000));
    chk("rst_data", 64'({unit_a[15:0], hi_wdata[15:0], lo_wdata[15:0], unit_b[15:0]}), 64'd0);
    #1 reset = 1'b0;
    idle(1);

    // Abort: reset pulse during WAIT (cycle 3) cancels the op with no HI/LO write.
    @(posedge clock); #1;
    md_req = 1'b1; md_op = 2'd0; rs_val = 32'd5; rt_val = 32'd6; unit_busy = 1'b0;
    @(posedge clock); #1;
    md_req = 1'b0;
    @(negedge clock);
    chk("abort_start", 64'(unit_start), 64'd1);
    @(posedge clock); #1 unit_busy = 1'b1;
    @(posedge clock); #1 unit_busy = 1'b1;
    #1 reset = 1'b1;
    #1 chk("abort_ctrl", 64'({pc_ena, unit_start, hilo_we, md_busy, dz, tmo}), 64'(6'b100000));
    #1 reset = 1'b0; unit_busy = 1'b0;
    idle(3);
    run_op(model(2'd0, 32'd5, 32'd6, 2), "after_abort", s1, w1);
    idle(1);

    // Randomized operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      logic [1:0]  op;
      logic [31:0] rs, rt;
      int          n;
      op = 2'($urandom_range(0, 3));
      rs = $urandom;
      rt = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
      n  = ($urandom_range(0, 7) == 0) ? STUCK : int'($urandom_range(0, 11));
      v  = model(op, rs, rt, n);
      run_op(v, $sformatf("rnd%0d", i), s1, w1);
      if ($urandom_range(0, 1) == 1) idle(1);
    end
    idle(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
